// File: rtl/dcnn_s0_ldctl.sv
`timescale 1ns/1ps
// dcnn_s0_ldctl: stage-0 core-side load sequencer.
// Drains weight stream 0, then feature stream 1, once per pass, and merges the
// words onto a single tagged output stream through one output register.
// Ports:
//   clk, arst_n           core clock, asynchronous active-low reset
//   cfg_start/kwords/
//   fwords/npass          layer configuration, latched on an accepted start
//   abort                 synchronous abort of the current layer
//   busy, done            layer in progress / one-cycle completion pulse
//   in0_*                 weight input stream (valid/ready/data)
//   in1_*                 feature input stream (valid/ready/data)
//   out_*                 merged output stream with weight/last/pass-last tags
module dcnn_s0_ldctl #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          cfg_start,
  input  logic [CW-1:0] cfg_kwords,
  input  logic [CW-1:0] cfg_fwords,
  input  logic [PW-1:0] cfg_npass,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  input  logic          in0_vld,
  output logic          in0_rdy,
  input  logic [DW-1:0] in0_data,
  input  logic          in1_vld,
  output logic          in1_rdy,
  input  logic [DW-1:0] in1_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic          out_is_w,
  output logic          out_last,
  output logic          out_pass_last
);

  typedef enum logic [1:0] {StIdle, StLdW, StLdF, StFlush} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] kwords_q, kwords_d;
  logic [CW-1:0] fwords_q, fwords_d;
  logic [PW-1:0] npass_q, npass_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          out_vld_q, out_vld_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_is_w_q, out_is_w_d;
  logic          out_last_q, out_last_d;
  logic          out_pass_last_q, out_pass_last_d;
  logic          done_q, done_d;

  logic ld;
  logic hs0, hs1;
  logic w_end, f_end, p_end;

  // The output register can take a new word when empty or draining this cycle.
  assign ld      = !out_vld_q || out_rdy;
  assign in0_rdy = (state_q == StLdW) && ld;
  assign in1_rdy = (state_q == StLdF) && ld;
  assign hs0     = in0_vld && in0_rdy;
  assign hs1     = in1_vld && in1_rdy;

  assign w_end = (wcnt_q + CW'(1)) == kwords_q;
  assign f_end = (wcnt_q + CW'(1)) == fwords_q;
  assign p_end = (pcnt_q + PW'(1)) == npass_q;

  always_comb begin
    state_d         = state_q;
    kwords_d        = kwords_q;
    fwords_d        = fwords_q;
    npass_d         = npass_q;
    wcnt_d          = wcnt_q;
    pcnt_d          = pcnt_q;
    out_vld_d       = out_vld_q;
    out_data_d      = out_data_q;
    out_is_w_d      = out_is_w_q;
    out_last_d      = out_last_q;
    out_pass_last_d = out_pass_last_q;
    done_d          = 1'b0;

    // Drain; a load below overrides this.
    if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          kwords_d = cfg_kwords;
          fwords_d = cfg_fwords;
          npass_d  = cfg_npass;
          wcnt_d   = '0;
          pcnt_d   = '0;
          if ((cfg_npass == '0) || ((cfg_kwords == '0) && (cfg_fwords == '0))) begin
            state_d = StFlush;
          end else if (cfg_kwords != '0) begin
            state_d = StLdW;
          end else begin
            state_d = StLdF;
          end
        end
      end

      StLdW: begin
        if (hs0) begin
          out_vld_d       = 1'b1;
          out_data_d      = in0_data;
          out_is_w_d      = 1'b1;
          out_last_d      = w_end;
          out_pass_last_d = 1'b0;
          if (w_end) begin
            wcnt_d = '0;
            if (fwords_q != '0) begin
              state_d = StLdF;
            end else begin
              // Weight-only layer: the weight phase closes the pass.
              pcnt_d = pcnt_q + PW'(1);
              if (p_end) begin
                state_d         = StFlush;
                out_pass_last_d = 1'b1;
              end
            end
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end

      StLdF: begin
        if (hs1) begin
          out_vld_d       = 1'b1;
          out_data_d      = in1_data;
          out_is_w_d      = 1'b0;
          out_last_d      = f_end;
          out_pass_last_d = 1'b0;
          if (f_end) begin
            wcnt_d = '0;
            pcnt_d = pcnt_q + PW'(1);
            if (p_end) begin
              state_d         = StFlush;
              out_pass_last_d = 1'b1;
            end else if (kwords_q != '0) begin
              state_d = StLdW;
            end else begin
              state_d = StLdF;
            end
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end

      StFlush: begin
        // Only the pass-last word can still be pending here.
        if (!out_vld_q || (out_vld_q && out_rdy && out_pass_last_q)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d   = StIdle;
      out_vld_d = 1'b0;
      wcnt_d    = '0;
      pcnt_d    = '0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q         <= StIdle;
      kwords_q        <= '0;
      fwords_q        <= '0;
      npass_q         <= '0;
      wcnt_q          <= '0;
      pcnt_q          <= '0;
      out_vld_q       <= 1'b0;
      out_data_q      <= '0;
      out_is_w_q      <= 1'b0;
      out_last_q      <= 1'b0;
      out_pass_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      kwords_q        <= kwords_d;
      fwords_q        <= fwords_d;
      npass_q         <= npass_d;
      wcnt_q          <= wcnt_d;
      pcnt_q          <= pcnt_d;
      out_vld_q       <= out_vld_d;
      out_data_q      <= out_data_d;
      out_is_w_q      <= out_is_w_d;
      out_last_q      <= out_last_d;
      out_pass_last_q <= out_pass_last_d;
      done_q          <= done_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign out_vld       = out_vld_q;
  assign out_data      = out_data_q;
  assign out_is_w      = out_is_w_q;
  assign out_last      = out_last_q;
  assign out_pass_last = out_pass_last_q;

endmodule

// File: tb/tb_dcnn_s0_ldctl.sv
`timescale 1ns/1ps
// Testbench for dcnn_s0_ldctl: table of layer configurations with hand-computed
// word counts and out_last position masks, plus abort and mid-layer reset sequences.
module tb_dcnn_s0_ldctl;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic [CW-1:0] cfg_kwords = '0;
  logic [CW-1:0] cfg_fwords = '0;
  logic [PW-1:0] cfg_npass = '0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic          in0_vld = 1'b0, in1_vld = 1'b0;
  logic          in0_rdy, in1_rdy;
  logic [DW-1:0] in0_data = '0, in1_data = '0;
  logic          out_vld, out_is_w, out_last, out_pass_last;
  logic          out_rdy = 1'b0;
  logic [DW-1:0] out_data;

  dcnn_s0_ldctl #(.DW(DW), .CW(CW), .PW(PW)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .cfg_start    (cfg_start),
    .cfg_kwords   (cfg_kwords),
    .cfg_fwords   (cfg_fwords),
    .cfg_npass    (cfg_npass),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .in0_vld      (in0_vld),
    .in0_rdy      (in0_rdy),
    .in0_data     (in0_data),
    .in1_vld      (in1_vld),
    .in1_rdy      (in1_rdy),
    .in1_data     (in1_data),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_data     (out_data),
    .out_is_w     (out_is_w),
    .out_last     (out_last),
    .out_pass_last(out_pass_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned w_idx = 0;  // next weight word index offered on in0
  int unsigned f_idx = 0;  // next feature word index offered on in1
  int unsigned hs0_cnt = 0;

  typedef struct {
    int unsigned kw, fw, np;
    bit          tog, rnd, mid;
    int unsigned exp_words, exp_in0;
    logic [31:0] exp_mask;  // bit n set: output word n+1 carries out_last
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle with both inputs valid and out_rdy high; tracks input handshakes.
  task automatic tick(input bit start, input bit ab);
    @(negedge clk);
    cfg_start = start;
    abort     = ab;
    in0_vld   = 1'b1;
    in1_vld   = 1'b1;
    in0_data  = 32'hA000_0000 + w_idx;
    in1_data  = 32'hB000_0000 + f_idx;
    out_rdy   = 1'b1;
    #1;
    if (in0_vld && in0_rdy) begin w_idx++; hs0_cnt++; end
    if (in1_vld && in1_rdy) f_idx++;
  endtask

  task automatic run_layer(input vec_t v, input int id);
    logic [31:0] ed[$];
    logic [2:0]  et[$];  // {is_w, last, pass_last}
    logic [2:0]  tmp;
    logic [31:0] lmask = '0;
    logic [31:0] prev_data = '0;
    int unsigned wb = w_idx, fb = f_idx;
    int unsigned n_out = 0, n0 = 0, n1 = 0;
    int          last_hs = -10, done_c = -1;
    bit          prev_stall = 1'b0;
    bit          zero = (v.np == 0) || ((v.kw == 0) && (v.fw == 0));

    if (!zero) begin
      for (int p = 0; p < int'(v.np); p++) begin
        for (int i = 0; i < int'(v.kw); i++) begin
          ed.push_back(32'hA000_0000 + wb); wb++;
          et.push_back({1'b1, i == int'(v.kw) - 1, 1'b0});
        end
        for (int i = 0; i < int'(v.fw); i++) begin
          ed.push_back(32'hB000_0000 + fb); fb++;
          et.push_back({1'b0, i == int'(v.fw) - 1, 1'b0});
        end
      end
      tmp = et[et.size() - 1];
      tmp[0] = 1'b1;
      et[et.size() - 1] = tmp;
    end

    for (int c = 0; c < 400 && done_c < 0; c++) begin
      @(negedge clk);
      cfg_start = 1'b0;
      abort     = 1'b0;
      if (c == 0) begin
        cfg_start  = 1'b1;
        cfg_kwords = CW'(v.kw);
        cfg_fwords = CW'(v.fw);
        cfg_npass  = PW'(v.np);
      end else if (v.mid && c == 4) begin
        cfg_start  = 1'b1;
        cfg_kwords = CW'(1);
        cfg_fwords = CW'(1);
        cfg_npass  = PW'(1);
      end
      in0_vld  = 1'b1;
      in0_data = 32'hA000_0000 + w_idx;
      in1_vld  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in1_data = 32'hB000_0000 + f_idx;
      out_rdy  = v.tog ? (c % 2 == 0) : 1'b1;
      #1;
      if (c == 1) chk($sformatf("v%0d busy_after_start", id), 32'(busy), 32'd1);
      if (in0_rdy && in1_rdy) chk($sformatf("v%0d both_rdy c%0d", id, c), 32'd1, 32'd0);
      if (prev_stall) begin
        chk($sformatf("v%0d hold_vld c%0d", id, c), 32'(out_vld), 32'd1);
        chk($sformatf("v%0d hold_data c%0d", id, c), out_data, prev_data);
      end
      if (out_vld && out_rdy) begin
        if (n_out < ed.size()) begin
          chk($sformatf("v%0d w%0d data", id, n_out), out_data, ed[n_out]);
          chk($sformatf("v%0d w%0d tags", id, n_out),
              {29'd0, out_is_w, out_last, out_pass_last}, {29'd0, et[n_out]});
        end else begin
          chk($sformatf("v%0d extra_word", id), 32'(n_out), 32'(ed.size()));
        end
        if (out_last && n_out < 32) lmask[n_out] = 1'b1;
        n_out++;
        last_hs = c;
      end
      if (in0_vld && in0_rdy) begin w_idx++; n0++; end
      if (in1_vld && in1_rdy) begin f_idx++; n1++; end
      if (done) begin
        done_c = c;
        chk($sformatf("v%0d busy_at_done", id), 32'(busy), 32'd0);
        chk($sformatf("v%0d done_cycle", id), 32'(c), zero ? 32'd2 : 32'(last_hs + 1));
      end
      prev_stall = out_vld && !out_rdy;
      prev_data  = out_data;
    end
    chk($sformatf("v%0d done_seen", id), 32'(done_c >= 0), 32'd1);
    chk($sformatf("v%0d n_words", id), 32'(n_out), 32'(v.exp_words));
    chk($sformatf("v%0d n_in0", id), 32'(n0), 32'(v.exp_in0));
    chk($sformatf("v%0d n_in1", id), 32'(n1), 32'(v.exp_words - v.exp_in0));
    chk($sformatf("v%0d last_mask", id), lmask, v.exp_mask);
  endtask

  initial begin
    vec_t rec;
    //          kw fw np tog rnd mid words in0 mask
    vecs[0] = '{3, 4, 2, 0, 0, 0, 14, 6, 32'h2244};
    vecs[1] = '{3, 4, 2, 1, 1, 0, 14, 6, 32'h2244};
    vecs[2] = '{3, 4, 0, 0, 0, 0, 0, 0, 32'h0};
    vecs[3] = '{0, 0, 5, 0, 0, 0, 0, 0, 32'h0};
    vecs[4] = '{0, 2, 3, 0, 0, 0, 6, 0, 32'h2A};
    vecs[5] = '{3, 4, 2, 0, 0, 1, 14, 6, 32'h2244};
    vecs[6] = '{1, 0, 3, 0, 0, 0, 3, 3, 32'h7};
    vecs[7] = '{1, 1, 1, 0, 0, 0, 2, 1, 32'h3};

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst out_vld", 32'(out_vld), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst tags", {29'd0, out_is_w, out_last, out_pass_last}, 32'd0);
    chk("rst rdy", {30'd0, in0_rdy, in1_rdy}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_layer(vecs[i], i);

    // Abort after five weight words; a start in the abort cycle must be ignored.
    cfg_kwords = CW'(8);
    cfg_fwords = CW'(2);
    cfg_npass  = PW'(1);
    hs0_cnt    = 0;
    tick(1'b1, 1'b0);
    for (int k = 0; k < 50 && hs0_cnt < 5; k++) tick(1'b0, 1'b0);
    chk("abort reach5", 32'(hs0_cnt), 32'd5);
    cfg_kwords = CW'(1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort out_vld", 32'(out_vld), 32'd0);
    chk("abort in0_rdy", 32'(in0_rdy), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b0);
      chk($sformatf("abort no_done %0d", k), {30'd0, done, busy}, 32'd0);
    end
    rec = '{2, 1, 1, 0, 0, 0, 3, 2, 32'h6};
    run_layer(rec, 8);

    // Asynchronous reset in the middle of a layer.
    cfg_kwords = CW'(3);
    cfg_fwords = CW'(4);
    cfg_npass  = PW'(2);
    tick(1'b1, 1'b0);
    repeat (4) tick(1'b0, 1'b0);
    chk("pre_rst busy", 32'(busy), 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst out_vld", 32'(out_vld), 32'd0);
    chk("arst out_data", out_data, 32'd0);
    chk("arst rdy", {30'd0, in0_rdy, in1_rdy}, 32'd0);
    chk("arst done", 32'(done), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    run_layer(vecs[7], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcnn_s0_ldctl.md
Name: dcnn_s0_ldctl

Overview:
Load sequencer on the core side of the stage-0 IO interface. It drains the two core-side input streams in a fixed layer order: weights from stream 0, then features from stream 1, repeated per pass. It merges them onto one tagged output stream that feeds the PE chain. Layer geometry is latched on a start strobe; the block reports busy and pulses done at layer end.

Parameters:
DW, 32, data word width of both input streams and the output stream
CW, 16, width of the word-count configuration fields
PW, 8, width of the pass-count configuration field

Ports:
clk  input  1  core clock
arst_n  input  1  asynchronous active-low reset
cfg_start  input  1  one-cycle strobe; latches cfg_* and starts a layer (ignored while busy)
cfg_kwords  input  CW  weight words per pass
cfg_fwords  input  CW  feature words per pass
cfg_npass  input  PW  number of passes
abort  input  1  synchronous abort of the current layer
busy  output  1  high from the cycle after accepted start until return to IDLE
done  output  1  one-cycle pulse when the last word of the last pass is accepted downstream
in0_vld  input  1  weight stream valid
in0_rdy  output  1  weight stream ready
in0_data  input  DW  weight stream data
in1_vld  input  1  feature stream valid
in1_rdy  output  1  feature stream ready
in1_data  input  DW  feature stream data
out_vld  output  1  output valid
out_rdy  input  1  output ready
out_data  output  DW  output data
out_is_w  output  1  1 = weight word, 0 = feature word
out_last  output  1  last word of the current phase
out_pass_last  output  1  out_last of the final feature (or weight-only) phase of the final pass

Behaviour:
- Reset values: state IDLE; busy, done, out_vld, out_is_w, out_last, out_pass_last = 0; out_data = 0; in0_rdy = in1_rdy = 0; all counters = 0.
- States: IDLE, LD_W, LD_F, FLUSH.
- IDLE: on cfg_start, latch cfg_*, clear word and pass counters.
  - If npass==0 or (kwords==0 and fwords==0): go to FLUSH, no data moved.
  - Else go to LD_W if kwords!=0, otherwise LD_F.
- Output stage: a single register. Load enable ld = !out_vld | out_rdy.
  - in0_rdy = (state==LD_W) & ld.
  - in1_rdy = (state==LD_F) & ld.
  - There is no combinational path from in*_vld to out_*.
- Latency: input word accepted in cycle N appears on out_data in cycle N+1.
- When out_vld & out_rdy and no new load occurs, out_vld clears.
- LD_W: each in0 handshake increments wcnt.
  - When wcnt==kwords-1, the word is tagged out_last=1, wcnt clears, and state goes to LD_F (or, if fwords==0, to the next pass / FLUSH).
- LD_F: same handling with in1 and fwords.
  - At phase end, pcnt increments.
  - If pcnt==npass-1, go to FLUSH; else go to LD_W (or LD_F if kwords==0).
- out_pass_last is set on the final word of the final pass.
- FLUSH: wait until the output register is empty, or is handing off the pass-last word (out_vld & out_rdy & out_pass_last).
  - Then: done=1 for one cycle, busy=0, state IDLE.
  - The zero-work case spends exactly one cycle in FLUSH: done is asserted 2 cycles after start.
- Arithmetic: counters are CW/PW bits unsigned. Compare with ==; no wrap is reachable. cfg values of 0 are handled as above.
- Only one input is ever ready in a cycle. The other stream is back-pressured even if valid.
- cfg_start while busy: ignored, no effect on latched config.
- abort (highest priority, any state): next cycle state IDLE, out_vld=0, counters cleared, busy=0, no done pulse.
  - abort and cfg_start in the same cycle: abort wins, start ignored.
- arst_n assertion mid-layer: all state returns to reset values immediately.

Test Plan:
- kwords=3, fwords=4, npass=2, out_rdy=1, both inputs always valid:
  - output sequence is W0-W2, F0-F3, W3-W5, F4-F7 (14 words, out_is_w tags match);
  - out_last on words 3, 7, 10 and 14; out_pass_last on word 14 only;
  - done 1 cycle after word 14 is accepted.
- Same config with out_rdy toggling 1010..., in1_vld random: no word lost or duplicated; in0_rdy/in1_rdy never high in the same cycle; out_data stable while out_vld & !out_rdy.
- npass=0, then kwords=0 & fwords=0 with npass=5: no in*_rdy ever asserted; done exactly 2 cycles after cfg_start.
- kwords=0, fwords=2, npass=3: 6 feature words with out_is_w=0; in0_rdy stays 0 throughout.
- abort asserted after 5 words of kwords=8: busy drops the next cycle, out_vld=0, no done; a fresh cfg_start then streams from word count 0.
- cfg_start pulsed mid-layer with different cfg values: ignored; the original layer completes with its original counts.
